// File: rtl/mult_result_accumulator_pkg.sv
// mult_acc_pkg: constants, state type and width helper for the product accumulator.
// Y_W           : product width, matched to the 20x18 unsigned multiplier Y port.
// acc_state_t   : two-state control (ACCUM collects beats, HOLD presents a result).
// acc_width()   : widened sum width so ACC_LEN full-scale products never overflow.
package mult_acc_pkg;

  localparam int Y_W = 38;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // ACC_LEN products of at most 2^y_w-1 each sum to less than 2^(y_w+clog2(acc_len)).
  function automatic int acc_width(input int y_w, input int acc_len);
    return y_w + $clog2(acc_len);
  endfunction

  function automatic int cnt_width(input int acc_len);
    return $clog2(acc_len + 1);
  endfunction

endpackage

// File: rtl/mult_result_accumulator_if.sv
// mult_result_accumulator_if: product-beat input and accumulated-result output bundle.
// Beat side : y_valid/y_ready handshake carrying y_data and the early-close flag y_last.
// Result side: acc_valid/acc_ready handshake carrying acc_data and its product count acc_count.
// master = environment (drives beats, accepts results); slave = accumulator.
interface mult_result_accumulator_if
  import mult_acc_pkg::*;
#(
  parameter int Y_W     = mult_acc_pkg::Y_W,
  parameter int ACC_LEN = 8
);

  localparam int ACC_W = acc_width(Y_W, ACC_LEN);
  localparam int CNT_W = cnt_width(ACC_LEN);

  logic             y_valid;
  logic             y_ready;
  logic [Y_W-1:0]   y_data;
  logic             y_last;

  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc_data;
  logic [CNT_W-1:0] acc_count;

  modport master (
    output y_valid,
    output y_data,
    output y_last,
    input  y_ready,
    input  acc_valid,
    input  acc_data,
    input  acc_count,
    output acc_ready
  );

  modport slave (
    input  y_valid,
    input  y_data,
    input  y_last,
    output y_ready,
    output acc_valid,
    output acc_data,
    output acc_count,
    input  acc_ready
  );

endinterface

// File: rtl/mult_result_accumulator.sv
// mult_result_accumulator: sums up to ACC_LEN consecutive unsigned products into one widened result.
// Latency: acc_valid rises on the edge after the closing beat is accepted; N beats + 1 handshake per result.
// Backpressure: while a result waits in HOLD, y_ready is low; no beat is taken in the handshake cycle.
// Ports: clock0 (rising edge), reset (sync, active high), bus (slave modport: y_* beats in, acc_* result out).
module mult_result_accumulator
  import mult_acc_pkg::*;
#(
  parameter int Y_W     = mult_acc_pkg::Y_W,
  parameter int ACC_LEN = 8
) (
  input  logic                        clock0,
  input  logic                        reset,
  mult_result_accumulator_if.slave    bus
);

  localparam int ACC_W = acc_width(Y_W, ACC_LEN);
  localparam int CNT_W = cnt_width(ACC_LEN);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_data_q, acc_data_d;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;
  logic             acc_valid_q, acc_valid_d;

  logic             y_ready_w;
  logic             beat_accept;
  logic [ACC_W-1:0] y_ext;
  logic [CNT_W-1:0] count_inc;
  logic             run_full;

  // Ready comes from registered state only, so upstream never sees a
  // combinational path from its own valid back to ready.
  assign y_ready_w   = (state_q == ACCUM) && !reset;
  assign beat_accept = bus.y_valid && y_ready_w;

  assign y_ext     = ACC_W'(bus.y_data);
  assign count_inc = acc_count_q + CNT_W'(1);
  assign run_full  = (count_inc == CNT_W'(ACC_LEN));

  always_comb begin
    state_d     = state_q;
    acc_data_d  = acc_data_q;
    acc_count_d = acc_count_q;
    acc_valid_d = acc_valid_q;

    case (state_q)
      ACCUM: begin
        if (beat_accept) begin
          // First beat of a run reloads, so the stale sum left behind by the
          // previous handshake never leaks into the new result.
          if (acc_count_q == '0) begin
            acc_data_d = y_ext;
          end else begin
            acc_data_d = acc_data_q + y_ext;
          end
          acc_count_d = count_inc;
          // y_last on the ACC_LEN-th beat still closes only once.
          if (run_full || bus.y_last) begin
            state_d     = HOLD;
            acc_valid_d = 1'b1;
          end
        end
      end

      HOLD: begin
        // acc_data is left as-is after the handshake; only count and valid clear.
        if (acc_valid_q && bus.acc_ready) begin
          state_d     = ACCUM;
          acc_count_d = '0;
          acc_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_data_q  <= '0;
      acc_count_q <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_count_q <= acc_count_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.y_ready   = y_ready_w;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_data  = acc_data_q;
  assign bus.acc_count = acc_count_q;

endmodule

// File: doc/mult_result_accumulator.md
# mult_result_accumulator

Downstream stage for the eight_mult_20x18_unsigned_regout multiplier bank. It consumes the registered 38-bit unsigned product stream `Y` and sums up to `ACC_LEN` consecutive products into one widened result. The finished sum is presented on a valid/ready output port. It sits between the multiplier output register and the result-collection logic.

## Interface
- `Y_W`, 38: product width; matches the multiplier `Y` port.
- `ACC_LEN`, 8: maximum number of products per accumulation; must be ≥ 2.
- `ACC_W`, `Y_W + $clog2(ACC_LEN)`: accumulator width (41 at defaults).
- `CNT_W`, `$clog2(ACC_LEN+1)`: beat-counter width (4 at defaults).

Ports:
- `clock0` in 1: single clock; all logic acts on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `y_valid` in 1: product beat valid.
- `y_ready` out 1: block can accept a beat.
- `y_data` in `Y_W`: unsigned product.
- `y_last` in 1: this beat closes the accumulation early.
- `acc_valid` out 1: result available.
- `acc_ready` in 1: downstream accepts the result.
- `acc_data` out `ACC_W`: unsigned sum.
- `acc_count` out `CNT_W`: number of products in `acc_data`.

## Operation
- State machine has two states: ACCUM (reset state) and HOLD.
- Reset values: state=ACCUM, `acc_data`=0, `acc_count`=0, `acc_valid`=0.
- `y_ready` = (state==ACCUM) && !`reset`. It is combinational from registered state only and never depends on `y_valid`.
- A beat is accepted when `y_valid && y_ready`.
- On an accepted beat in ACCUM:
  - If `acc_count`==0, the accumulator loads `y_data` (zero-extended). Otherwise it loads `acc_data + y_data`.
  - `acc_count` increments.
- ACCUM→HOLD when an accepted beat makes `acc_count`==`ACC_LEN`, or when the accepted beat carries `y_last`.
- `y_last` on a non-accepted cycle is ignored. `y_last` on the `ACC_LEN`-th beat gives one transition, not two.
- In HOLD:
  - `acc_valid`=1.
  - `acc_data` and `acc_count` are frozen.
  - `y_ready`=0.
- HOLD→ACCUM on `acc_valid && acc_ready`. On that edge `acc_count`→0 and `acc_valid`→0.
- `acc_data` keeps its stale value after the handshake. It is reloaded on the next first beat.
- There is no bypass: a beat offered in the handshake cycle is not accepted that cycle.
- Arithmetic is unsigned and cannot overflow: the maximum sum is `ACC_LEN`·(2^`Y_W`−1) < 2^`ACC_W`.
- `reset` asserted in any state, including mid-accumulation or in HOLD, discards the partial or pending sum and restores the reset values on the next edge. `reset` has priority over every handshake.
- `acc_ready` in ACCUM has no effect.

## Timing
- Latency: `acc_valid` rises on the edge after the closing beat is accepted (1 cycle).
- Throughput: N beats plus at least 1 handshake cycle per result. Back-to-back results need N+1 cycles.
- All outputs except `y_ready` are registered.
- `acc_data` and `acc_count` are stable for the whole time `acc_valid`=1.
- `y_valid` may toggle freely. Gaps between beats do not affect the sum.

## Structure
- Package `mult_acc_pkg` holds:
  - constant `Y_W`=38 (shared with the multiplier testbenches);
  - the state enum `acc_state_t` {ACCUM, HOLD};
  - a function computing `ACC_W` from `Y_W` and `ACC_LEN`.
- Single flat module. No sub-module is needed, because the datapath is one adder plus one counter.
- Testbench pairs the RTL with its post-route netlist and compares `acc_data`/`acc_count`/`acc_valid` every negedge with `!==`, counting mismatches.

## Test plan
- Full run: 8 beats of `y_data`=2^38−1 with `acc_ready`=1 → `acc_valid` the cycle after beat 8, `acc_data`=2199023255544 (2^41−8), `acc_count`=8.
- Early close: beats 5, 7, 9 with `y_last` on the 9 → `acc_data`=21, `acc_count`=3. Beats 4 and later are not accepted until the handshake.
- Single-beat close: one beat of 123456 with `y_last` → `acc_data`=123456, `acc_count`=1. The next run of 2, 3 with `y_last` gives 5, proving the accumulator reloads.
- Backpressure: after a closed run of sum 100, hold `acc_ready`=0 for 4 cycles with `y_valid`=1 → `y_ready`=0, `acc_data`=100 stable. On `acc_ready`=1, one handshake follows, then `y_ready`=1.
- Reset mid-operation: accept 5 beats of 10, assert `reset` 1 cycle → `acc_valid`=0, `acc_count`=0. Then 8 beats of 1 → `acc_data`=8, `acc_count`=8.
- Random: 50 runs of random length 1..8, random `y_data` in [0, 2^38−1], random `acc_ready` gaps → matches the scoreboard sum, and the netlist matches RTL.
